// File: rtl/addsub4_checker_pkg.sv
// addsub4_checker_pkg: shared state encoding and constants for the add/sub checker.
package addsub4_checker_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;
    localparam logic [7:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/addsub4_checker_if.sv
// addsub4_checker_if: vector stream into the checker plus its run status and counters.
interface addsub4_checker_if;
    logic       start;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sel;
    logic [3:0] sum;
    logic       cout;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
    logic       err;
    logic [9:0] fail_info;
    modport master (
        output start, in_valid, a, b, cin, sel, sum, cout,
        input  in_ready, busy, done, pass_cnt, fail_cnt, err, fail_info
    );
    modport slave (
        input  start, in_valid, a, b, cin, sel, sum, cout,
        output in_ready, busy, done, pass_cnt, fail_cnt, err, fail_info
    );
endinterface

// File: rtl/addsub4_ref.sv
// addsub4_ref: golden 4-bit add/subtract; subtract is a + ~b + 1 with cin ignored.
module addsub4_ref
    import addsub4_checker_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sel,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] nb;
    always_comb begin
        nb = ~b;
        {cout, sum} = (sel == SEL_SUB) ? {1'b0, a} + {1'b0, nb} + 5'd1
                                       : {1'b0, a} + {1'b0, b} + {4'd0, cin};
    end
endmodule

// File: rtl/addsub4_checker.sv
// addsub4_checker: checks observed add/sub results against addsub4_ref over a run of
// NUM_VECTORS accepted vectors, with saturating pass/fail counts and first-failure capture.
module addsub4_checker
    import addsub4_checker_pkg::*;
#(
    parameter int NUM_VECTORS = 8
) (
    input logic              clk,
    input logic              rst_n,
    addsub4_checker_if.slave bus
);
    localparam logic [9:0] LAST = 10'(NUM_VECTORS - 1);
    state_t     state, state_nx;
    logic [9:0] acc;
    logic       cmp_vld, cmp_cin, cmp_sel, cmp_cout, exp_cout;
    logic [3:0] cmp_a, cmp_b, cmp_sum, exp_sum;
    logic       xfer, go, match;

    addsub4_ref u_ref (
        .a(cmp_a), .b(cmp_b), .cin(cmp_cin), .sel(cmp_sel), .sum(exp_sum), .cout(exp_cout)
    );

    assign xfer         = bus.in_valid && state == RUN;
    assign go           = bus.start && (state == IDLE || state == DONE);
    assign match        = cmp_sum == exp_sum && cmp_cout == exp_cout;
    assign bus.in_ready = state == RUN;
    assign bus.busy     = state == RUN || state == DRAIN;
    assign bus.done     = state == DONE;

    always_comb begin
        state_nx = go ? RUN : (xfer && acc == LAST) ? DRAIN : (state == DRAIN) ? DONE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // The verdict of a vector lands one edge after its transfer, so DRAIN retires the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {cmp_vld, cmp_sel, cmp_cin, cmp_a, cmp_b, cmp_sum, cmp_cout} <= '0;
            acc           <= '0;
            bus.pass_cnt  <= '0;
            bus.fail_cnt  <= '0;
            bus.err       <= 1'b0;
            bus.fail_info <= '0;
        end else begin
            cmp_vld <= xfer;
            if (xfer) {cmp_sel, cmp_cin, cmp_a, cmp_b, cmp_sum, cmp_cout} <=
                {bus.sel, bus.cin, bus.a, bus.b, bus.sum, bus.cout};
            if (go) begin
                acc           <= '0;
                bus.pass_cnt  <= '0;
                bus.fail_cnt  <= '0;
                bus.err       <= 1'b0;
                bus.fail_info <= '0;
            end else begin
                if (xfer) acc <= acc + 10'd1;
                if (cmp_vld && match && bus.pass_cnt != CNT_MAX) bus.pass_cnt <= bus.pass_cnt + 8'd1;
                if (cmp_vld && !match) begin
                    if (bus.fail_cnt != CNT_MAX) bus.fail_cnt <= bus.fail_cnt + 8'd1;
                    if (!bus.err) begin
                        bus.err       <= 1'b1;
                        bus.fail_info <= {cmp_sel, cmp_cin, cmp_a, cmp_b};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub4_checker.sv
// tb_addsub4_checker: three checker instances (4, 2 and 300 vectors) against an arithmetic model.
module tb_addsub4_checker;
    logic clk = 1'b0, rst_n = 1'b0;
    logic st4 = 1'b0, st2 = 1'b0, st300 = 1'b0;
    logic iv = 1'b0, cin = 1'b0, sel = 1'b0, cout = 1'b0;
    logic [3:0] a = '0, b = '0, sum = '0;
    always #5 clk = ~clk;

    addsub4_checker_if i4 (), i2 (), i300 ();
    assign i4.start   = st4;
    assign i2.start   = st2;
    assign i300.start = st300;
    assign {i4.in_valid, i4.a, i4.b, i4.cin, i4.sel, i4.sum, i4.cout} = {iv, a, b, cin, sel, sum, cout};
    assign {i2.in_valid, i2.a, i2.b, i2.cin, i2.sel, i2.sum, i2.cout} = {iv, a, b, cin, sel, sum, cout};
    assign {i300.in_valid, i300.a, i300.b, i300.cin, i300.sel, i300.sum, i300.cout} =
        {iv, a, b, cin, sel, sum, cout};

    addsub4_checker #(.NUM_VECTORS(4))   d4   (.clk(clk), .rst_n(rst_n), .bus(i4));
    addsub4_checker #(.NUM_VECTORS(2))   d2   (.clk(clk), .rst_n(rst_n), .bus(i2));
    addsub4_checker #(.NUM_VECTORS(300)) d300 (.clk(clk), .rst_n(rst_n), .bus(i300));

    logic [7:0] pc [3], fc [3];
    logic [9:0] fi [3];
    logic       er [3], dn [3], by [3], rdy [3];
    assign {pc[0], fc[0], fi[0], er[0], dn[0], by[0], rdy[0]} =
        {i4.pass_cnt, i4.fail_cnt, i4.fail_info, i4.err, i4.done, i4.busy, i4.in_ready};
    assign {pc[1], fc[1], fi[1], er[1], dn[1], by[1], rdy[1]} =
        {i2.pass_cnt, i2.fail_cnt, i2.fail_info, i2.err, i2.done, i2.busy, i2.in_ready};
    assign {pc[2], fc[2], fi[2], er[2], dn[2], by[2], rdy[2]} =
        {i300.pass_cnt, i300.fail_cnt, i300.fail_info, i300.err, i300.done, i300.busy, i300.in_ready};

    int errors = 0, checks = 0;
    int m_pass, m_fail;
    logic m_err;
    logic [9:0] m_info;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [3:0] va, vb, input logic vc, vs);
        int r;
        r = vs ? int'(va) + 16 - int'(vb) : int'(va) + int'(vb) + int'(vc);
        return r[4:0];
    endfunction

    task automatic send(input logic [3:0] va, vb, input logic vc, vs, input logic [3:0] vsum,
                        input logic vco);
        if ({vco, vsum} == model(va, vb, vc, vs)) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
        else begin
            m_fail = (m_fail < 255) ? m_fail + 1 : 255;
            if (!m_err) begin
                m_err  = 1'b1;
                m_info = {vs, vc, va, vb};
            end
        end
        {a, b, cin, sel, sum, cout} = {va, vb, vc, vs, vsum, vco};
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic send_rand(input bit good);
        logic [3:0] va, vb;
        logic vc, vs;
        logic [4:0] r;
        va = 4'($urandom_range(0, 15));
        vb = 4'($urandom_range(0, 15));
        vc = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        r  = good ? model(va, vb, vc, vs) : 5'($urandom_range(0, 31));
        send(va, vb, vc, vs, r[3:0], r[4]);
    endtask

    task automatic pulse(input int w);
        m_pass = 0;
        m_fail = 0;
        m_err  = 1'b0;
        m_info = '0;
        st4 = (w == 4);
        st2 = (w == 2);
        st300 = (w == 300);
        @(negedge clk);
        {st4, st2, st300} = 3'b000;
    endtask

    task automatic final_check(input int k, input string tag);
        check({tag, ".done"}, dn[k], 1);
        check({tag, ".busy"}, by[k], 0);
        check({tag, ".in_ready"}, rdy[k], 0);
        check({tag, ".pass_cnt"}, pc[k], m_pass);
        check({tag, ".fail_cnt"}, fc[k], m_fail);
        check({tag, ".err"}, er[k], m_err);
        check({tag, ".fail_info"}, fi[k], m_info);
    endtask

    task automatic zero_check(input int k, input string tag);
        check({tag, ".zero"}, {pc[k], fc[k], fi[k], er[k], dn[k], by[k], rdy[k]}, 0);
    endtask

    initial begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) zero_check(k, "reset");
        rst_n = 1'b1;
        // vectors offered while idle must be ignored
        iv = 1'b1;
        repeat (5) begin
            {a, b, cin, sel, sum, cout} = 14'($urandom);
            @(negedge clk);
            check("idle.in_ready", rdy[0], 0);
        end
        iv = 1'b0;
        check("idle.pass_cnt", pc[0], 0);
        check("idle.fail_cnt", fc[0], 0);
        check("idle.done", dn[0], 0);

        pulse(4);
        check("run4.in_ready", rdy[0], 1);
        check("run4.busy", by[0], 1);
        send(4'd5, 4'd1, 1'b0, 1'b0, 4'd6, 1'b0);
        send(4'd5, 4'd1, 1'b0, 1'b1, 4'd4, 1'b1);
        send(4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1);
        send(4'd1, 4'd5, 1'b0, 1'b1, 4'd12, 1'b0);
        check("run4.drain_done", dn[0], 0);
        check("run4.drain_busy", by[0], 1);
        check("run4.drain_ready", rdy[0], 0);
        @(negedge clk);
        final_check(0, "run4");
        check("run4.pass4", pc[0], 4);

        pulse(2);
        send(4'd2, 4'd2, 1'b0, 1'b0, 4'd5, 1'b0);
        send(4'd2, 4'd2, 1'b0, 1'b1, 4'd15, 1'b0);
        repeat (2) @(negedge clk);
        final_check(1, "run2");
        check("run2.info_lit", fi[1], 10'b00_0010_0010);
        check("run2.fail2", fc[1], 2);

        // random pass/fail mix; a start in RUN must not clear the run
        pulse(4);
        send_rand($urandom_range(0, 1) == 1);
        st4 = 1'b1;
        send_rand($urandom_range(0, 1) == 1);
        st4 = 1'b0;
        check("rand4.still_busy", by[0], 1);
        send_rand(1'b0);
        send_rand($urandom_range(0, 1) == 1);
        repeat (2) @(negedge clk);
        final_check(0, "rand4");

        // asynchronous reset mid-run with a verdict still pending
        pulse(4);
        send_rand(1'b1);
        send_rand(1'b0);
        #2 rst_n = 1'b0;
        #1 zero_check(0, "midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        zero_check(0, "postreset");
        pulse(4);
        repeat (4) send_rand(1'b1);
        repeat (2) @(negedge clk);
        final_check(0, "clean4");

        pulse(300);
        for (int n = 0; n < 300;) begin
            if ($urandom_range(0, 1) == 1) begin
                check("run300.early_done", dn[2], 0);
                send_rand(1'b1);
                n++;
            end else @(negedge clk);
        end
        check("run300.drain_done", dn[2], 0);
        @(negedge clk);
        final_check(2, "run300");
        check("run300.sat", pc[2], 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
